// File: rtl/instruction_fetch.sv
// Instruction fetch front end: holds the PC, issues in-order word reads to instruction
// memory and buffers returned words with their PCs for decode; redirects flush everything.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        fetch_error
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = CW + 2;
   localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
   logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
   logic          fetch_error_q, fetch_error_d;

   logic [31:0]   fifo_data_q [DEPTH];
   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   pcq_q       [DEPTH];

   logic [OW-1:0] occupancy;
   logic          pop, req_fire, resp_keep, flush, fifo_push;

   always_comb begin
      pop       = (count_q != '0) && instr_ready;
      occupancy = OW'(inflight_q) + OW'(discard_q) + OW'(count_q);
      flush     = redirect && (state_q == RUN);
      // A slot freed by this cycle's decode pop can be reused immediately, which is
      // what lets a single-cycle memory sustain one word per cycle.
      imem_req_valid = rst_n && (state_q == RUN) && !redirect &&
                       ((occupancy - OW'(pop)) < DEPTH_O);
      req_fire  = imem_req_valid && imem_req_ready;
      resp_keep = imem_resp_valid && (discard_q == '0);
      fifo_push = rst_n && !flush && resp_keep;

      state_d       = state_q;
      pc_d          = pc_q;
      inflight_d    = inflight_q;
      discard_d     = discard_q;
      count_d       = count_q;
      fifo_wr_d     = fifo_wr_q;
      fifo_rd_d     = fifo_rd_q;
      pcq_wr_d      = pcq_wr_q;
      pcq_rd_d      = pcq_rd_q;
      fetch_error_d = fetch_error_q;

      if (flush) begin
         pc_d       = redirect_target;
         count_d    = '0;
         fifo_wr_d  = '0;
         fifo_rd_d  = '0;
         pcq_wr_d   = '0;
         pcq_rd_d   = '0;
         inflight_d = '0;
         // Every owed response becomes a discard, minus the one dropped right now.
         discard_d  = discard_q + inflight_q - CW'(imem_resp_valid);
         if (redirect_target[1:0] != 2'b00) begin
            state_d       = HALT;
            fetch_error_d = 1'b1;
         end
      end else begin
         if (req_fire) begin
            pc_d     = pc_q + 32'd4;
            pcq_wr_d = pcq_wr_q + PTR_ONE;
         end
         if (imem_resp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_ONE;
         end
         if (resp_keep) begin
            fifo_wr_d = fifo_wr_q + PTR_ONE;
            pcq_rd_d  = pcq_rd_q + PTR_ONE;
         end
         if (pop) begin
            fifo_rd_d = fifo_rd_q + PTR_ONE;
         end
         inflight_d = inflight_q + CW'(req_fire) - CW'(resp_keep);
         count_d    = count_q + CW'(resp_keep) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         inflight_q    <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         fifo_wr_q     <= '0;
         fifo_rd_q     <= '0;
         pcq_wr_q      <= '0;
         pcq_rd_q      <= '0;
         fetch_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_rd_q     <= fifo_rd_d;
         pcq_wr_q      <= pcq_wr_d;
         pcq_rd_q      <= pcq_rd_d;
         fetch_error_q <= fetch_error_d;
      end
   end

   // Storage arrays carry no reset; the counters decide what is meaningful.
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_data_q[fifo_wr_q] <= imem_resp_data;
         fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
      end
      if (req_fire) begin
         pcq_q[pcq_wr_q] <= pc_q;
      end
   end

   assign imem_req_addr = pc_q;
   assign instr_valid   = (count_q != '0);
   assign instr         = instr_valid ? fifo_data_q[fifo_rd_q] : 32'h0;
   assign instr_pc      = instr_valid ? fifo_pc_q[fifo_rd_q] : 32'h0;
   assign fetch_error   = fetch_error_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order latency-configurable memory model plus a
// scoreboard of expected {pc, word} deliveries rebuilt at every reset/redirect.
module tb_instruction_fetch;
   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam int          DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b1;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b1;
   logic        fetch_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .redirect(redirect),
      .redirect_target(redirect_target), .instr_valid(instr_valid),
      .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .fetch_error(fetch_error)
   );

   typedef struct {
      int          due;
      logic [31:0] addr;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] exp_q[$];
   int          mem_lat = 1;
   int          cyc = 0;
   int          req_cnt = 0;
   int          del_cnt = 0;
   logic        fire_s, resp_s, rst_s;
   logic [31:0] addr_s;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'hA5A5_0F0F;
   endfunction

   // Memory model: sample the handshake mid-cycle, apply it just after the edge.
   always @(negedge clk) begin
      fire_s = imem_req_valid && imem_req_ready;
      addr_s = imem_req_addr;
      resp_s = imem_resp_valid;
      rst_s  = rst_n;
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst_s) begin
         pend_q.delete();
         req_cnt = 0;
      end else begin
         if (resp_s && pend_q.size() > 0) pend_q.delete(0);
         if (fire_s) begin
            pend_q.push_back('{cyc + mem_lat, addr_s});
            req_cnt++;
         end
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend_q[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_from(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 48; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic do_reset(input int lat);
      rst_n    = 1'b0;
      redirect = 1'b0;
      mem_lat  = lat;
      tick();
      tick();
      rst_n = 1'b1;
      expect_from(RPC);
      del_cnt = 0;
   endtask

   task automatic test_reset();
      instr_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b, want 0", imem_req_valid); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid: got %b, want 0", instr_valid); end
      total++; if (fetch_error !== 1'b0) begin bad++; $display("FAIL rst_fetch_error: got %b, want 0", fetch_error); end
      total++; if (imem_req_addr !== RPC) begin bad++; $display("FAIL rst_addr: got %h, want %h", imem_req_addr, RPC); end
      total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h, want 0", instr); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc: got %h, want 0", instr_pc); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_from(RPC);
      del_cnt = 0;
   endtask

   task automatic test_stream();
      logic [31:0] e;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c <= 3) begin
            total++;
            if (!(imem_req_valid === 1'b1 && imem_req_addr === RPC + 32'(4 * (c - 1)))) begin
               bad++; $display("FAIL req_seq c=%0d: got valid=%b addr=%h, want valid=1 addr=%h",
                               c, imem_req_valid, imem_req_addr, RPC + 32'(4 * (c - 1)));
            end
         end
         total++;
         if (instr_valid !== (c >= 3)) begin
            bad++; $display("FAIL valid_timing c=%0d: got %b, want %b", c, instr_valid, (c >= 3));
         end
         if (instr_valid && instr_ready) begin
            total++; del_cnt++;
            $display("deliver pc=%h instr=%h", instr_pc, instr);
            if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h, want none", instr_pc); end
            else begin
               e = exp_q.pop_front();
               if (instr_pc !== e || instr !== mem_word(e)) begin
                  bad++; $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e, mem_word(e));
               end
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      logic [31:0] hold;
      int          d0;
      instr_ready = 1'b0;
      hold = 32'h0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) hold = instr_pc;
         else begin
            total++;
            if (instr_valid !== 1'b1 || instr_pc !== hold) begin
               bad++; $display("FAIL stall_stable c=%0d: got valid=%b pc=%h, want valid=1 pc=%h", c, instr_valid, instr_pc, hold);
            end
         end
         if (c == 9) begin
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b, want 0", imem_req_valid); end
            total++; if (req_cnt - del_cnt != DEPTH) begin bad++; $display("FAIL stall_buffered: got %0d, want %0d", req_cnt - del_cnt, DEPTH); end
            total++; if (exp_q.size() == 0 || hold !== exp_q[0]) begin bad++; $display("FAIL stall_head: got %h, want expected head", hold); end
         end
         tick();
      end
      instr_ready = 1'b1;
      d0 = del_cnt;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            total++; del_cnt++;
            $display("deliver pc=%h instr=%h", instr_pc, instr);
            if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h, want none", instr_pc); end
            else begin
               e = exp_q.pop_front();
               if (instr_pc !== e || instr !== mem_word(e)) begin
                  bad++; $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e, mem_word(e));
               end
            end
         end
         tick();
      end
      total++; if (del_cnt - d0 < 6) begin bad++; $display("FAIL resume_rate: got %0d deliveries, want >=6", del_cnt - d0); end
   endtask

   task automatic test_redirect_pop();
      logic [31:0] e;
      int          d0;
      redirect        = 1'b1;
      redirect_target = 32'h0000_0300;
      @(negedge clk);
      total++;
      if (!(imem_resp_valid === 1'b1 && instr_valid === 1'b1)) begin
         bad++; $display("FAIL pop_setup: got resp=%b valid=%b, want 1 1", imem_resp_valid, instr_valid);
      end
      if (instr_valid && instr_ready) begin
         total++; del_cnt++;
         $display("deliver pc=%h instr=%h", instr_pc, instr);
         if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h, want none", instr_pc); end
         else begin
            e = exp_q.pop_front();
            if (instr_pc !== e || instr !== mem_word(e)) begin
               bad++; $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e, mem_word(e));
            end
         end
      end
      expect_from(32'h0000_0300);
      tick();
      redirect = 1'b0;
      @(negedge clk);
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL pop_flush_valid: got %b, want 0", instr_valid); end
      total++; if (imem_req_addr !== 32'h300) begin bad++; $display("FAIL pop_addr: got %h, want 00000300", imem_req_addr); end
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL pop_req_valid: got %b, want 1", imem_req_valid); end
      tick();
      d0 = del_cnt;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            total++; del_cnt++;
            $display("deliver pc=%h instr=%h", instr_pc, instr);
            if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h, want none", instr_pc); end
            else begin
               e = exp_q.pop_front();
               if (instr_pc !== e || instr !== mem_word(e)) begin
                  bad++; $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e, mem_word(e));
               end
            end
         end
         tick();
      end
      total++; if (del_cnt == d0) begin bad++; $display("FAIL pop_timeout: got 0 deliveries, want >0"); end
   endtask

   task automatic test_redirect_stale();
      logic [31:0] e;
      do_reset(3);
      tick();
      tick();
      redirect        = 1'b1;
      redirect_target = 32'h0000_0200;
      @(negedge clk);
      total++; if (req_cnt != 2) begin bad++; $display("FAIL stale_outstanding: got %0d, want 2", req_cnt); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stale_pre_valid: got %b, want 0", instr_valid); end
      expect_from(32'h0000_0200);
      tick();
      redirect = 1'b0;
      @(negedge clk);
      total++; if (imem_req_addr !== 32'h200) begin bad++; $display("FAIL stale_addr: got %h, want 00000200", imem_req_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stale_flush_valid: got %b, want 0", instr_valid); end
      tick();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            total++; del_cnt++;
            $display("deliver pc=%h instr=%h", instr_pc, instr);
            if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h, want none", instr_pc); end
            else begin
               e = exp_q.pop_front();
               if (instr_pc !== e || instr !== mem_word(e)) begin
                  bad++; $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e, mem_word(e));
               end
            end
         end
         tick();
      end
      total++; if (del_cnt == 0) begin bad++; $display("FAIL stale_timeout: got 0 deliveries, want >0"); end
   endtask

   task automatic test_misaligned();
      logic [31:0] e;
      redirect        = 1'b1;
      redirect_target = 32'h0000_0202;
      @(negedge clk);
      if (instr_valid && instr_ready) begin
         total++; del_cnt++;
         $display("deliver pc=%h instr=%h", instr_pc, instr);
         if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h, want none", instr_pc); end
         else begin
            e = exp_q.pop_front();
            if (instr_pc !== e || instr !== mem_word(e)) begin
               bad++; $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e, mem_word(e));
            end
         end
      end
      exp_q.delete();
      tick();
      for (int c = 1; c <= 20; c++) begin
         redirect        = (c == 10);
         redirect_target = 32'h0000_0400;
         @(negedge clk);
         total++; if (fetch_error !== 1'b1) begin bad++; $display("FAIL halt_error c=%0d: got %b, want 1", c, fetch_error); end
         total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL halt_req c=%0d: got %b, want 0", c, imem_req_valid); end
         total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_valid c=%0d: got %b pc=%h, want 0", c, instr_valid, instr_pc); end
         total++; if (imem_req_addr !== 32'h202) begin bad++; $display("FAIL halt_addr c=%0d: got %h, want 00000202", c, imem_req_addr); end
         tick();
      end
      redirect = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      logic [31:0] reqs[$];
      logic [31:0] want[3];
      do_reset(1);
      @(negedge clk);
      total++; if (fetch_error !== 1'b0) begin bad++; $display("FAIL reset_clears_error: got %b, want 0", fetch_error); end
      total++;
      if (!(imem_req_valid === 1'b1 && imem_req_addr === RPC)) begin
         bad++; $display("FAIL restart_req: got valid=%b addr=%h, want 1 %h", imem_req_valid, imem_req_addr, RPC);
      end
      tick();
      redirect        = 1'b1;
      redirect_target = 32'hFFFF_FFF8;
      @(negedge clk);
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL wrap_pre_valid: got %b, want 0", instr_valid); end
      expect_from(32'hFFFF_FFF8);
      tick();
      redirect = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) reqs.push_back(imem_req_addr);
         if (instr_valid && instr_ready) begin
            total++; del_cnt++;
            $display("deliver pc=%h instr=%h", instr_pc, instr);
            if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h, want none", instr_pc); end
            else begin
               e = exp_q.pop_front();
               if (instr_pc !== e || instr !== mem_word(e)) begin
                  bad++; $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e, mem_word(e));
               end
            end
         end
         tick();
      end
      want[0] = 32'hFFFF_FFF8;
      want[1] = 32'hFFFF_FFFC;
      want[2] = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (reqs.size() <= i) begin bad++; $display("FAIL wrap_req%0d: got none, want %h", i, want[i]); end
         else if (reqs[i] !== want[i]) begin bad++; $display("FAIL wrap_req%0d: got %h, want %h", i, reqs[i], want[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_pop();
      test_redirect_stale();
      test_misaligned();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
